dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory access stage directly downstream of the single-cycle datapath. It consumes ALUResult (address) and WriteData and returns ReadData to the result mux. It turns the datapath's combinational memory strobes into a registered req/ready transaction on a variable-latency memory bus. It raises Stall to freeze the PC and register file until the access completes, and checks word alignment and bus timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32 for lane logic)
TIMEOUT, 255, max BUS-state cycles waiting for mem_ready before abort (8-bit counter)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MemRead  in  1  load strobe from control unit
MemWrite  in  1  store strobe from control unit
ByteAccess  in  1  1 = LDRB/STRB, 0 = word
ALUResult  in  ADDR_W  effective address from datapath
WriteData  in  DATA_W  store data from datapath
ReadData  out  DATA_W  load data to result mux
Stall  out  1  1 = hold PC/regfile write this cycle
AlignErr  out  1  one-cycle pulse: misaligned word access
BusErr  out  1  one-cycle pulse: timeout abort
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  DATA_W  write data
mem_be  out  4  byte enables
mem_ready  in  1  bus accept/complete
mem_rdata  in  DATA_W  read data, valid when mem_ready

Behaviour:
- Reset (async, reset=0): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData, AlignErr, BusErr, and the timeout counter all 0. A reset mid-transaction drops mem_req immediately. The bus must tolerate an abandoned request.
- FSM states: IDLE, BUS, DONE.
- IDLE with MemRead|MemWrite=1:
  - Stall=1 combinationally in the same cycle.
  - Capture address, data, ByteAccess and direction.
  - MemWrite wins if both strobes are high; the access is then a write.
  - Word access with ALUResult[1:0]!=0: no bus request; go to DONE with AlignErr set, ReadData=0.
  - Otherwise: mem_req<=1 and go to BUS.
- IDLE with no strobe: Stall=0, outputs hold.
- BUS:
  - Stall=1; mem_req, mem_we, mem_addr, mem_wdata and mem_be are stable.
  - mem_req && mem_ready: handshake. On the edge, mem_req<=0; on a read, latch ReadData; go to DONE.
  - No ready: counter increments. When counter==TIMEOUT-1 without ready: mem_req<=0, BusErr set, ReadData<=0, go to DONE.
- DONE:
  - Stall=0, so the datapath commits the load/store at this edge.
  - AlignErr and BusErr are high only in this cycle.
  - Counter clears; return to IDLE unconditionally. Strobes seen in DONE belong to the finishing instruction and are ignored.
- Latency:
  - Zero-wait bus: a memory instruction takes 3 cycles (Stall high 2).
  - Each extra wait cycle adds 1.
  - Misaligned access: 2 cycles.
- Byte lanes:
  - Word access: mem_be=4'b1111, mem_wdata=WriteData.
  - Byte store: mem_be=4'b0001<<addr[1:0], mem_wdata={4{WriteData[7:0]}}.
  - Byte load: ReadData={24'b0, selected lane of mem_rdata}, zero-extended.
- ReadData holds its last value until the next completed load. It is not cleared by stores.

Decomposition:
- Package cpu_pkg holds:
  - the dmem_state_t enum (IDLE, BUS, DONE);
  - constants BE_WORD=4'b1111 and BE_BYTE0=4'b0001;
  - TIMEOUT_W=8.
- Sub-module mem_lane_align (combinational) holds the byte-enable generation, store replication and load lane select/zero-extension. dmem_ctrl keeps the FSM, capture registers and timeout counter.

Test Plan:
- Word load, zero-wait: addr 0x0000_0010, mem_rdata=0xDEAD_BEEF with ready in first BUS cycle -> Stall 1,1,0; mem_be=1111; ReadData=0xDEADBEEF in DONE; total 3 cycles.
- Byte store, 3 wait cycles: addr 0x0000_0023, WriteData=0x1234_56AB -> mem_addr=0x20, mem_be=1000, mem_wdata=0xABABABAB held stable for 4 BUS cycles; Stall high 5 cycles.
- Byte load lane select: addr 0x0000_0041, mem_rdata=0x11223344 -> ReadData=0x00000033.
- Misaligned word load at 0x0000_0006 -> mem_req never asserts; AlignErr pulses 1 cycle; ReadData=0; Stall high 1 cycle.
- Timeout: mem_ready held 0 for TIMEOUT=4 -> mem_req drops after 4 BUS cycles; BusErr pulses once; ReadData=0; FSM returns to IDLE.
- Reset mid-BUS (reset=0 on cycle 2 of a wait) -> mem_req, Stall and all outputs 0 immediately; after release, the next load completes normally; MemRead+MemWrite together issues mem_we=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory access stage.
// Holds the controller state encoding and the byte-enable constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam logic [3:0] BE_BYTE0  = 4'b0001;
  localparam int         TIMEOUT_W = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the datapath and a 32-bit word-addressed bus.
// Stores are replicated across lanes with a one-hot enable; loads pick one lane and zero-extend.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic        st_byte_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic        ld_byte_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0] ld_lane;

  always_comb begin
    st_be_o    = BE_WORD;
    st_wdata_o = st_wdata_i;
    if (st_byte_i) begin
      st_be_o    = BE_BYTE0 << st_off_i;
      st_wdata_o = {4{st_wdata_i[7:0]}};
    end
  end

  always_comb begin
    ld_lane = 8'h00;
    case (ld_off_i)
      2'd0:    ld_lane = ld_rdata_i[7:0];
      2'd1:    ld_lane = ld_rdata_i[15:8];
      2'd2:    ld_lane = ld_rdata_i[23:16];
      default: ld_lane = ld_rdata_i[31:24];
    endcase
    ld_data_o = ld_rdata_i;
    if (ld_byte_i) ld_data_o = {24'h000000, ld_lane};
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access stage: registers the datapath's memory strobes into a req/ready
// bus transaction, stalls the pipeline until it completes, and flags misalignment/timeouts.
module dmem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ByteAccess,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              AlignErr,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  dmem_state_t          state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [1:0]           off_q, off_d;
  logic                 byte_q, byte_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 align_q, align_d;
  logic                 buserr_q, buserr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic                 access;
  logic                 misaligned;
  logic [3:0]           lane_be;
  logic [DATA_W-1:0]    lane_wdata;
  logic [DATA_W-1:0]    lane_rdata;

  assign access     = MemRead | MemWrite;
  assign misaligned = !ByteAccess && (ALUResult[1:0] != 2'b00);

  // Store steering uses the live datapath inputs; load steering uses the captured offset.
  mem_lane_align u_lane (
    .st_byte_i  (ByteAccess),
    .st_off_i   (ALUResult[1:0]),
    .st_wdata_i (WriteData),
    .st_be_o    (lane_be),
    .st_wdata_o (lane_wdata),
    .ld_byte_i  (byte_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    off_d    = off_q;
    byte_d   = byte_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    align_d  = 1'b0;
    buserr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          off_d  = ALUResult[1:0];
          byte_d = ByteAccess;
          if (misaligned) begin
            align_d = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALUResult[ADDR_W-1:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end

      BUS: begin
        if (req_q && mem_ready) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = lane_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
          rdata_d  = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Strobes are still up for the finishing instruction; never re-issue here.
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      off_q    <= 2'b00;
      byte_q   <= 1'b0;
      rdata_q  <= '0;
      align_q  <= 1'b0;
      buserr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      off_q    <= off_d;
      byte_q   <= byte_d;
      rdata_q  <= rdata_d;
      align_q  <= align_d;
      buserr_q <= buserr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset gates the combinational stall so a held strobe cannot freeze the pipeline during reset.
  assign Stall     = reset & (((state_q == IDLE) & access) | (state_q == BUS));
  assign ReadData  = rdata_q;
  assign AlignErr  = align_q;
  assign BusErr    = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a transaction-level memory model predicts bus
// requests and completion results; a bus responder and a completion monitor check them.
module tb_dmem_ctrl;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        align;
    logic        buserr;
    int          stalls;
  } sb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, ByteAccess = 1'b0;
  logic [31:0] ALUResult = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, AlignErr, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b0;

  sb_exp_t     sb_q[$];
  bus_exp_t    bus_q[$];
  logic [31:0] mem[16];
  logic [31:0] last_rd = '0;

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .ByteAccess(ByteAccess),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .AlignErr(AlignErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Bus responder: checks each request against the predicted one and answers after its wait count.
  initial begin : responder
    bit       active;
    int       cyc;
    bus_exp_t b;
    active = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset || !sb_en || !mem_req) begin
        mem_ready = 1'b0;
        active = 1'b0;
      end else begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            chk("bus_unexpected_req", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            active = 1'b1;
            cyc = 0;
          end
        end
        if (active) begin
          chk("bus_we", {31'd0, mem_we}, {31'd0, b.we});
          chk("bus_addr", mem_addr, b.addr);
          chk("bus_be", {28'd0, mem_be}, {28'd0, b.be});
          if (b.we) chk("bus_wdata", mem_wdata, b.wdata);
          if (cyc == b.waits) begin
            mem_ready = 1'b1;
            mem_rdata = b.rdata;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom();
          end
          cyc++;
        end
      end
    end
  end

  // Completion monitor: a falling Stall marks the finishing cycle of an instruction.
  initial begin : monitor
    bit      prev;
    int      scnt;
    sb_exp_t e;
    prev = 1'b0;
    scnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!sb_en) begin
        prev = 1'b0;
        scnt = 0;
      end else begin
        if (Stall) scnt++;
        if (prev && !Stall) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("done_readdata", ReadData, e.rdata);
            chk("done_alignerr", {31'd0, AlignErr}, {31'd0, e.align});
            chk("done_buserr", {31'd0, BusErr}, {31'd0, e.buserr});
            chk("stall_cycles", scnt, e.stalls);
          end
          scnt = 0;
        end else if (AlignErr || BusErr) begin
          chk("err_pulse_outside_done", {30'd0, AlignErr, BusErr}, 32'd0);
        end
        prev = Stall;
      end
    end
  end

  // Predicts the outcome from the memory model, then drives the strobes until the access finishes.
  task automatic issue(input bit rd, input bit wr, input bit byt,
                       input logic [31:0] addr, input logic [31:0] wd, input int waits);
    sb_exp_t  e;
    bus_exp_t b;
    int       idx;
    int       off;
    bit       done;
    idx = int'(addr[5:2]);
    off = int'(addr[1:0]);
    if (!byt && off != 0) begin
      last_rd = '0;
      e.stalls = 1;
      e.align = 1'b1;
      e.buserr = 1'b0;
    end else begin
      b.we    = wr;
      b.addr  = addr & 32'hFFFF_FFFC;
      b.be    = byt ? 4'(1 << off) : 4'hF;
      b.wdata = byt ? {4{wd[7:0]}} : wd;
      b.rdata = mem[idx];
      b.waits = waits;
      bus_q.push_back(b);
      e.align = 1'b0;
      if (waits >= TO) begin
        last_rd = '0;
        e.buserr = 1'b1;
        e.stalls = TO + 1;
      end else begin
        e.buserr = 1'b0;
        e.stalls = waits + 2;
        if (wr) begin
          if (byt) mem[idx][8*off +: 8] = wd[7:0];
          else     mem[idx] = wd;
        end else begin
          last_rd = byt ? ((mem[idx] >> (8 * off)) & 32'h0000_00FF) : mem[idx];
        end
      end
    end
    e.rdata = last_rd;
    sb_q.push_back(e);

    MemRead = rd; MemWrite = wr; ByteAccess = byt;
    ALUResult = addr; WriteData = wd;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!Stall) done = 1'b1;
    end
    if (!done) begin
      chk("issue_cycle_budget", 32'd0, 32'd1);
      finish_run();
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin : stimulus
    logic [31:0] a;
    int          op;
    int          w;
    bit          byt;
    for (int i = 0; i < 16; i++) mem[i] = $urandom();

    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_bus_fields", mem_addr | mem_wdata | {28'd0, mem_be} | {31'd0, mem_we}, 32'd0);
    chk("rst_err_flags", {30'd0, AlignErr, BusErr}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;

    mem[4] = 32'hDEAD_BEEF;
    issue(1, 0, 0, 32'h0000_0010, 32'h0, 0);
    issue(0, 1, 1, 32'h0000_0023, 32'h1234_56AB, 3);
    mem[0] = 32'h1122_3344;
    issue(1, 0, 1, 32'h0000_0041, 32'h0, 0);
    issue(1, 0, 0, 32'h0000_0006, 32'h0, 0);
    issue(1, 0, 0, 32'h0000_0020, 32'h0, 0);
    issue(1, 0, 0, 32'h0000_0030, 32'h0, TO);
    issue(1, 0, 0, 32'h0000_0020, 32'h0, 1);

    // Reset in the middle of a waiting bus access.
    @(negedge clk);
    sb_en = 1'b0;
    MemRead = 1'b1; ByteAccess = 1'b0; ALUResult = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("req_before_reset", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midreset_stall", {31'd0, Stall}, 32'd0);
    chk("midreset_readdata", ReadData, 32'd0);
    chk("midreset_bus_fields", mem_addr | mem_wdata | {28'd0, mem_be} | {31'd0, mem_we}, 32'd0);
    last_rd = '0;
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;

    issue(1, 0, 0, 32'h0000_0010, 32'h0, 2);
    issue(1, 1, 0, 32'h0000_0014, 32'hCAFE_F00D, 0);
    issue(1, 0, 0, 32'h0000_0014, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      op  = $urandom_range(0, 5);
      byt = $urandom_range(0, 1) == 1;
      a   = $urandom();
      if (!byt && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      w   = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
      if (op < 3)       issue(1, 0, byt, a, $urandom(), w);
      else if (op < 5)  issue(0, 1, byt, a, $urandom(), w);
      else              issue(1, 1, byt, a, $urandom(), w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_queue_drained", sb_q.size(), 32'd0);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #500000;
    chk("global_time_limit", 32'd0, 32'd1);
    finish_run();
  end

endmodule
